// File: rtl/sphere_loader_pkg.sv
// sphere_loader_pkg: shared types for the sphere loader.
//   sphere_t        packed sphere record, MSB first: x, y, z, r, c (64 bits)
//   SPHERE_BYTES    bytes per record on the MCU stream
//   SPHERE_W        record width in bits
//   loader_state_e  loader FSM states
package sphere_loader_pkg;

  localparam int SPHERE_BYTES = 8;

  typedef struct packed {
    logic [15:0] x;
    logic [13:0] y;
    logic [15:0] z;
    logic [5:0]  r;
    logic [11:0] c;
  } sphere_t;

  localparam int SPHERE_W = $bits(sphere_t);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } loader_state_e;

endpackage

// File: rtl/sphere_loader_if.sv
// sphere_loader_if: MCU byte stream, renderer swap/read port and status.
//   frame_sync, byte_in, byte_valid   MCU scene stream
//   swap_req, rd_idx, rd_sphere       renderer side
//   active_count, pending, busy, load_err, dbg_state   status / debug
//
// Handshake: byte_in is sampled on every rising clk edge where byte_valid
// is high and the loader is collecting bytes. There is no ready; the loader
// accepts at most one byte per cycle and never stalls the sender.
// frame_sync and swap_req are single-cycle pulses.
interface sphere_loader_if
  import sphere_loader_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
) ();
  logic                frame_sync;
  logic [7:0]          byte_in;
  logic                byte_valid;
  logic                swap_req;
  logic [IDX_W-1:0]    rd_idx;
  logic [SPHERE_W-1:0] rd_sphere;
  logic [CNT_W-1:0]    active_count;
  logic                pending;
  logic                busy;
  logic                load_err;
  loader_state_e       dbg_state;

  modport slave (
    input  frame_sync, byte_in, byte_valid, swap_req, rd_idx,
    output rd_sphere, active_count, pending, busy, load_err, dbg_state
  );

  modport master (
    output frame_sync, byte_in, byte_valid, swap_req, rd_idx,
    input  rd_sphere, active_count, pending, busy, load_err, dbg_state
  );
endinterface

// File: rtl/sphere_loader_assembler.sv
// sphere_loader_assembler: collects 8 bytes MSB first into one sphere record.
//   clk, rst       clock, synchronous active-high reset
//   i_clr          abort the record in progress (frame_sync)
//   i_en           accept i_byte this cycle
//   i_byte         incoming byte
//   o_word_valid   high in the cycle the 8th byte is accepted
//   o_word         completed record, valid with o_word_valid
module sphere_loader_assembler
  import sphere_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic       o_word_valid,
  output sphere_t    o_word
);
  // Only the first seven bytes need storing; the eighth is taken straight
  // from i_byte so the record is available in the cycle it completes.
  logic [SPHERE_W-9:0] r_shift;
  logic [2:0]          r_byte_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (i_en) begin
      r_shift    <= {r_shift[SPHERE_W-17:0], i_byte};
      r_byte_cnt <= r_byte_cnt + 3'd1;  // wraps to 0 after the 8th byte
    end
  end

  assign o_word_valid = i_en && (r_byte_cnt == 3'(SPHERE_BYTES - 1));
  assign o_word       = sphere_t'({r_shift, i_byte});

endmodule

// File: rtl/sphere_loader.sv
// sphere_loader: loads scene packets (count byte + N 8-byte records) into the
// shadow bank of a double-buffered sphere table; the renderer reads the active
// bank and swaps banks at frame boundaries.
//   clk, rst   clock, synchronous active-high reset
//   bus        sphere_loader_if.slave (stream in, read port, status out)
module sphere_loader
  import sphere_loader_pkg::*;
#(
  parameter int MAX_SPHERES = 8,
  parameter int IDX_W       = $clog2(MAX_SPHERES),
  parameter int CNT_W       = IDX_W + 1
) (
  input logic            clk,
  input logic            rst,
  sphere_loader_if.slave bus
);
  loader_state_e    r_state, w_state_next;
  logic             r_active;
  logic             r_pending;
  logic             r_load_err;
  logic [CNT_W-1:0] r_count [2];
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_sphere_cnt;
  sphere_t          r_tab [2][MAX_SPHERES];
  sphere_t          r_rd_sphere;

  logic             w_asm_en, w_word_valid;
  sphere_t          w_word;
  logic             w_zero, w_oversize, w_start, w_complete;
  logic             w_done, w_swap;
  logic [CNT_W-1:0] w_done_cnt;

  sphere_loader_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (bus.frame_sync),
    .i_en         (w_asm_en),
    .i_byte       (bus.byte_in),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  assign w_asm_en = bus.byte_valid && !bus.frame_sync && (r_state == DATA);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // frame_sync overrides everything, so no completion can coincide with it.
  always_comb begin
    w_state_next = r_state;
    w_zero       = 1'b0;
    w_oversize   = 1'b0;
    w_start      = 1'b0;
    w_complete   = 1'b0;
    if (bus.frame_sync) begin
      w_state_next = COUNT;
    end else begin
      case (r_state)
        COUNT: if (bus.byte_valid) begin
          if (bus.byte_in == 8'd0) begin
            w_zero       = 1'b1;
            w_state_next = IDLE;
          end else if ({1'b0, bus.byte_in} > 9'(MAX_SPHERES)) begin
            w_oversize   = 1'b1;
            w_state_next = DISCARD;
          end else begin
            w_start      = 1'b1;
            w_state_next = DATA;
          end
        end
        DATA: if (w_word_valid && (r_sphere_cnt == r_n - CNT_W'(1))) begin
          w_complete   = 1'b1;
          w_state_next = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign w_done     = w_zero || w_complete;
  assign w_done_cnt = w_zero ? '0 : r_n;
  // A scene completing this cycle is swappable immediately; otherwise the
  // swap sees pending as it was before this cycle.
  assign w_swap     = bus.swap_req && (r_pending || w_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active     <= 1'b0;
      r_pending    <= 1'b0;
      r_load_err   <= 1'b0;
      r_count[0]   <= '0;
      r_count[1]   <= '0;
      r_n          <= '0;
      r_sphere_cnt <= '0;
    end else begin
      if (w_swap) r_active <= ~r_active;
      // Shadow index uses the bank before any toggle in this cycle.
      if (w_done) r_count[~r_active] <= w_done_cnt;
      if (w_swap)                r_pending <= 1'b0;
      else if (w_done)           r_pending <= 1'b1;
      if (bus.frame_sync)        r_pending <= 1'b0;
      if (w_oversize)            r_load_err <= 1'b1;
      if (w_start) begin
        r_load_err <= 1'b0;
        r_n        <= CNT_W'(bus.byte_in);
      end
      if (bus.frame_sync)        r_sphere_cnt <= '0;
      else if (w_word_valid)     r_sphere_cnt <= r_sphere_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < MAX_SPHERES; i++)
          r_tab[b][i] <= '0;
      r_rd_sphere <= '0;
    end else begin
      if (w_word_valid) r_tab[~r_active][r_sphere_cnt[IDX_W-1:0]] <= w_word;
      r_rd_sphere <= r_tab[r_active][bus.rd_idx];
    end
  end

  assign bus.rd_sphere    = r_rd_sphere;
  assign bus.active_count = r_count[r_active];
  assign bus.pending      = r_pending;
  assign bus.busy         = (r_state == COUNT) || (r_state == DATA);
  assign bus.load_err     = r_load_err;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_sphere_loader.sv
module tb_sphere_loader;
  import sphere_loader_pkg::*;

  localparam int MAX_SPHERES = 8;
  localparam int IDX_W       = 3;
  localparam int CNT_W       = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sphere_loader_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus_if ();

  sphere_loader #(.MAX_SPHERES(MAX_SPHERES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int gap_max = 0;

  // scoreboard and reference scene model
  logic [63:0] exp_q[$];
  logic [63:0] act_scene [MAX_SPHERES];
  int          act_cnt = 0;
  logic [63:0] new_scene [MAX_SPHERES];
  int          new_cnt = 0;
  logic [63:0] got, exp_v;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.frame_sync = 1'b0;
    bus_if.byte_in    = 8'd0;
    bus_if.byte_valid = 1'b0;
    bus_if.swap_req   = 1'b0;
    bus_if.rd_idx     = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, gap_max)) tick();
    bus_if.byte_in    = b;
    bus_if.byte_valid = 1'b1;
    tick();
    bus_if.byte_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    bus_if.frame_sync = 1'b1;
    tick();
    bus_if.frame_sync = 1'b0;
  endtask

  task automatic pulse_swap();
    bus_if.swap_req = 1'b1;
    tick();
    bus_if.swap_req = 1'b0;
  endtask

  task automatic send_rec(input logic [63:0] rec);
    for (int b = 7; b >= 0; b--) send_byte(rec[b*8 +: 8]);
  endtask

  task automatic load_scene(input int n);
    pulse_frame();
    send_byte(8'(n));
    new_cnt = n;
    for (int i = 0; i < n; i++) begin
      new_scene[i] = {$urandom(), $urandom()};
      send_rec(new_scene[i]);
    end
  endtask

  task automatic commit_model();
    for (int i = 0; i < MAX_SPHERES; i++) act_scene[i] = new_scene[i];
    act_cnt = new_cnt;
  endtask

  task automatic read_idx(input int idx, output logic [63:0] val);
    bus_if.rd_idx = IDX_W'(idx);
    tick();
    val = bus_if.rd_sphere;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_vec++; if (bus_if.rd_sphere !== 64'd0) begin n_err++; $display("FAIL reset_rd_sphere: got %h want 0", bus_if.rd_sphere); end
    n_vec++; if (bus_if.active_count !== 4'd0) begin n_err++; $display("FAIL reset_active_count: got %0d want 0", bus_if.active_count); end
    n_vec++; if (bus_if.pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0", bus_if.pending); end
    n_vec++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    n_vec++; if (bus_if.load_err !== 1'b0) begin n_err++; $display("FAIL reset_load_err: got %b want 0", bus_if.load_err); end
    n_vec++; if (bus_if.dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus_if.dbg_state); end
    for (int i = 0; i < MAX_SPHERES; i++) begin
      exp_q.push_back(64'd0);
      read_idx(i, got);
      exp_v = exp_q.pop_front();
      n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL reset_table[%0d]: got %h want %h", i, got, exp_v); end
    end
  endtask

  task automatic test_single();
    pulse_frame();
    n_vec++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_count: got %b want 1", bus_if.busy); end
    send_byte(8'h01);
    new_cnt = 1;
    new_scene[0] = 64'h0010_0080_0400_5F00;
    send_rec(new_scene[0]);
    n_vec++; if (bus_if.pending !== 1'b1) begin n_err++; $display("FAIL single_pending: got %b want 1", bus_if.pending); end
    n_vec++; if (bus_if.active_count !== 4'd0) begin n_err++; $display("FAIL single_count_preswap: got %0d want 0", bus_if.active_count); end
    n_vec++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_done: got %b want 0", bus_if.busy); end
    pulse_swap();
    commit_model();
    n_vec++; if (bus_if.active_count !== 4'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus_if.active_count); end
    n_vec++; if (bus_if.pending !== 1'b0) begin n_err++; $display("FAIL single_pending_swap: got %b want 0", bus_if.pending); end
    exp_q.push_back(64'h0010_0080_0400_5F00);
    read_idx(0, got);
    exp_v = exp_q.pop_front();
    n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL single_read: got %h want %h", got, exp_v); end
  endtask

  task automatic test_bank_isolation();
    load_scene(2);
    pulse_swap();
    commit_model();
    n_vec++; if (bus_if.active_count !== 4'd2) begin n_err++; $display("FAIL iso_count_A: got %0d want 2", bus_if.active_count); end
    load_scene(3);
    n_vec++; if (bus_if.pending !== 1'b1) begin n_err++; $display("FAIL iso_pending_B: got %b want 1", bus_if.pending); end
    n_vec++; if (bus_if.active_count !== 4'd2) begin n_err++; $display("FAIL iso_count_hold: got %0d want 2", bus_if.active_count); end
    for (int i = 0; i < act_cnt; i++) begin
      exp_q.push_back(act_scene[i]);
      read_idx(i, got);
      exp_v = exp_q.pop_front();
      n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL iso_read_A[%0d]: got %h want %h", i, got, exp_v); end
    end
    pulse_swap();
    commit_model();
    n_vec++; if (bus_if.active_count !== 4'd3) begin n_err++; $display("FAIL iso_count_B: got %0d want 3", bus_if.active_count); end
    for (int i = 0; i < act_cnt; i++) begin
      exp_q.push_back(act_scene[i]);
      read_idx(i, got);
      exp_v = exp_q.pop_front();
      n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL iso_read_B[%0d]: got %h want %h", i, got, exp_v); end
    end
  endtask

  task automatic test_oversize();
    pulse_frame();
    send_byte(8'h09);
    n_vec++; if (bus_if.load_err !== 1'b1) begin n_err++; $display("FAIL over_load_err: got %b want 1", bus_if.load_err); end
    n_vec++; if (bus_if.dbg_state !== DISCARD) begin n_err++; $display("FAIL over_state: got %0d want 3", bus_if.dbg_state); end
    repeat (72) send_byte(8'($urandom_range(0, 255)));
    n_vec++; if (bus_if.pending !== 1'b0) begin n_err++; $display("FAIL over_pending: got %b want 0", bus_if.pending); end
    n_vec++; if (bus_if.load_err !== 1'b1) begin n_err++; $display("FAIL over_sticky: got %b want 1", bus_if.load_err); end
    pulse_swap();
    n_vec++; if (bus_if.active_count !== 4'(act_cnt)) begin n_err++; $display("FAIL over_count: got %0d want %0d", bus_if.active_count, act_cnt); end
    for (int i = 0; i < act_cnt; i++) begin
      exp_q.push_back(act_scene[i]);
      read_idx(i, got);
      exp_v = exp_q.pop_front();
      n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL over_read[%0d]: got %h want %h", i, got, exp_v); end
    end
    pulse_frame();
    send_byte(8'h01);
    n_vec++; if (bus_if.load_err !== 1'b0) begin n_err++; $display("FAIL over_err_clear: got %b want 0", bus_if.load_err); end
    new_cnt = 1;
    new_scene[0] = {$urandom(), $urandom()};
    send_rec(new_scene[0]);
    pulse_swap();
    commit_model();
    n_vec++; if (bus_if.active_count !== 4'd1) begin n_err++; $display("FAIL over_recover_count: got %0d want 1", bus_if.active_count); end
  endtask

  task automatic test_abort();
    // a finished but unswapped scene is dropped by the next frame_sync
    load_scene(2);
    n_vec++; if (bus_if.pending !== 1'b1) begin n_err++; $display("FAIL abort_pending_pre: got %b want 1", bus_if.pending); end
    pulse_frame();
    n_vec++; if (bus_if.pending !== 1'b0) begin n_err++; $display("FAIL abort_pending_drop: got %b want 0", bus_if.pending); end
    send_byte(8'h02);
    repeat (11) send_byte(8'($urandom_range(0, 255)));
    pulse_frame();
    send_byte(8'h01);
    new_cnt = 1;
    new_scene[0] = {$urandom(), $urandom()};
    send_rec(new_scene[0]);
    n_vec++; if (bus_if.pending !== 1'b1) begin n_err++; $display("FAIL abort_pending: got %b want 1", bus_if.pending); end
    pulse_swap();
    commit_model();
    n_vec++; if (bus_if.active_count !== 4'd1) begin n_err++; $display("FAIL abort_count: got %0d want 1", bus_if.active_count); end
    exp_q.push_back(act_scene[0]);
    read_idx(0, got);
    exp_v = exp_q.pop_front();
    n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL abort_read: got %h want %h", got, exp_v); end
  endtask

  task automatic test_zero_swap();
    pulse_frame();
    bus_if.byte_in    = 8'h00;
    bus_if.byte_valid = 1'b1;
    bus_if.swap_req   = 1'b1;
    tick();
    bus_if.byte_valid = 1'b0;
    bus_if.swap_req   = 1'b0;
    act_cnt = 0;
    n_vec++; if (bus_if.active_count !== 4'd0) begin n_err++; $display("FAIL zero_count: got %0d want 0", bus_if.active_count); end
    n_vec++; if (bus_if.pending !== 1'b0) begin n_err++; $display("FAIL zero_pending: got %b want 0", bus_if.pending); end
    n_vec++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", bus_if.busy); end
    // swap with nothing pending must leave the banks alone
    pulse_swap();
    n_vec++; if (bus_if.active_count !== 4'd0) begin n_err++; $display("FAIL zero_noswap: got %0d want 0", bus_if.active_count); end
  endtask

  task automatic test_frame_swap();
    load_scene(2);
    bus_if.frame_sync = 1'b1;
    bus_if.swap_req   = 1'b1;
    tick();
    bus_if.frame_sync = 1'b0;
    bus_if.swap_req   = 1'b0;
    commit_model();
    n_vec++; if (bus_if.active_count !== 4'd2) begin n_err++; $display("FAIL fswap_count: got %0d want 2", bus_if.active_count); end
    n_vec++; if (bus_if.pending !== 1'b0) begin n_err++; $display("FAIL fswap_pending: got %b want 0", bus_if.pending); end
    n_vec++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL fswap_busy: got %b want 1", bus_if.busy); end
    send_byte(8'h00);
    n_vec++; if (bus_if.pending !== 1'b1) begin n_err++; $display("FAIL fswap_zero_pending: got %b want 1", bus_if.pending); end
    for (int i = 0; i < act_cnt; i++) begin
      exp_q.push_back(act_scene[i]);
      read_idx(i, got);
      exp_v = exp_q.pop_front();
      n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL fswap_read[%0d]: got %h want %h", i, got, exp_v); end
    end
    pulse_swap();
    act_cnt = 0;
    n_vec++; if (bus_if.active_count !== 4'd0) begin n_err++; $display("FAIL fswap_zero_count: got %0d want 0", bus_if.active_count); end
  endtask

  task automatic test_back_to_back();
    gap_max = 3;
    for (int s = 0; s < 4; s++) begin
      load_scene($urandom_range(1, MAX_SPHERES));
      pulse_swap();
      commit_model();
      n_vec++; if (bus_if.active_count !== 4'(act_cnt)) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want %0d", s, bus_if.active_count, act_cnt); end
      for (int i = 0; i < act_cnt; i++) begin
        exp_q.push_back(act_scene[i]);
        read_idx(i, got);
        exp_v = exp_q.pop_front();
        n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL b2b_read[%0d][%0d]: got %h want %h", s, i, got, exp_v); end
      end
    end
    gap_max = 0;
  endtask

  task automatic test_reset_mid_data();
    bus_if.rd_idx = '0;
    pulse_frame();
    send_byte(8'h03);
    repeat (5) send_byte(8'($urandom_range(0, 255)));
    n_vec++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL rstdata_busy_pre: got %b want 1", bus_if.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    act_cnt = 0;
    n_vec++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL rstdata_busy: got %b want 0", bus_if.busy); end
    n_vec++; if (bus_if.pending !== 1'b0) begin n_err++; $display("FAIL rstdata_pending: got %b want 0", bus_if.pending); end
    n_vec++; if (bus_if.active_count !== 4'd0) begin n_err++; $display("FAIL rstdata_count: got %0d want 0", bus_if.active_count); end
    n_vec++; if (bus_if.rd_sphere !== 64'd0) begin n_err++; $display("FAIL rstdata_rd_sphere: got %h want 0", bus_if.rd_sphere); end
    for (int i = 0; i < MAX_SPHERES; i++) begin
      exp_q.push_back(64'd0);
      read_idx(i, got);
      exp_v = exp_q.pop_front();
      n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL rstdata_table[%0d]: got %h want %h", i, got, exp_v); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_bank_isolation();
    test_oversize();
    test_abort();
    test_zero_swap();
    test_frame_swap();
    test_back_to_back();
    test_reset_mid_data();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
